// File: rtl/kpg_pkg.sv
// kpg_pkg: KPG carry-code type, encodings and prefix/classify helpers shared by prefix adders.
package kpg_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_K = 2'b00;
    localparam kpg_t KPG_P = 2'b01;
    localparam kpg_t KPG_G = 2'b10;

    function automatic kpg_t kpg_combine(kpg_t hi, kpg_t lo);
        return (hi == KPG_P) ? lo : hi;
    endfunction

    function automatic kpg_t kpg_classify(logic a_bit, logic b_bit);
        return (a_bit & b_bit) ? KPG_G : (a_bit | b_bit) ? KPG_P : KPG_K;
    endfunction

endpackage

// File: rtl/kpg_prefix32.sv
// kpg_prefix32: combinational Kogge-Stone KPG prefix, x[32:0] -> carry codes y[31:0] plus full-span code c.
module kpg_prefix32
    import kpg_pkg::*;
(
    input  kpg_t [32:0] x_i,
    output kpg_t [31:0] y_o,
    output kpg_t        c_o
);

    kpg_t [32:0] l [7];

    always_comb begin
        l[0] = x_i;
        for (int k = 0; k < 6; k++) begin
            l[k+1] = l[k];
            for (int i = (1 << k); i < 33; i++)
                l[k+1][i] = kpg_combine(l[k][i], l[k][i-(1<<k)]);
        end
    end

    // Span 33 reaches the top slot; the lower 32 slots are complete after five levels.
    assign y_o = l[6][31:0];
    assign c_o = l[6][32];

endmodule

// File: rtl/sub32_kpg_pipe.sv
// sub32_kpg_pipe: 3-stage KPG prefix subtractor/comparator (a - b) with valid/ready handshake.
module sub32_kpg_pipe
    import kpg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             lt_s
);

    logic             adv;
    logic [1:0]       v_q;
    kpg_t [WIDTH:0]   x_d, x1_q;
    kpg_t [WIDTH-1:0] y, y2_q;
    kpg_t             c, t2_q;
    logic [WIDTH-1:0] p_d, p2_q, diff_d;
    logic             co_d, ovf_d;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & rst_n;

    kpg_prefix32 u_prefix (.x_i(x1_q), .y_o(y), .c_o(c));

    always_comb begin
        x_d[0] = KPG_G;
        for (int i = 0; i < WIDTH; i++) begin
            x_d[i+1]  = kpg_classify(a[i], ~b[i]);
            p_d[i]    = (x1_q[i+1] == KPG_P);
            diff_d[i] = p2_q[i] ^ (y2_q[i] == KPG_G);
        end
        co_d  = (t2_q == KPG_P) ? (y2_q[WIDTH-1] == KPG_G) : (t2_q == KPG_G);
        // Top code is G/K exactly when a and b differ in sign; G means a is negative.
        ovf_d = ((t2_q == KPG_G) & ~diff_d[WIDTH-1]) | ((t2_q == KPG_K) & diff_d[WIDTH-1]);
    end

    always_comb
        if (rst_n)
            assert (c != 2'b11 && y != '1 && c == ((x1_q[WIDTH] == KPG_P) ? y[WIDTH-1] : x1_q[WIDTH]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            x1_q      <= '0;
            y2_q      <= '0;
            p2_q      <= '0;
            t2_q      <= KPG_K;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            lt_s      <= 1'b0;
        end else begin
            if (flush) begin
                v_q       <= '0;
                out_valid <= 1'b0;
            end else if (adv) begin
                v_q       <= {v_q[0], in_valid};
                out_valid <= v_q[1];
            end
            if (adv) begin
                x1_q   <= x_d;
                y2_q   <= y;
                p2_q   <= p_d;
                t2_q   <= x1_q[WIDTH];
                diff   <= diff_d;
                borrow <= ~co_d;
                ovf    <= ovf_d;
                zero   <= ~|diff_d;
                lt_s   <= diff_d[WIDTH-1] ^ ovf_d;
            end
        end
    end

endmodule
